// File: rtl/logic_op_issuer.sv
// Initiator for the combinational 16-bit logic unit: takes commands,
// drives registered A/B/F, captures Out and Z/N/P, returns a response.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/ready       command handshake (cmd_f, cmd_a, cmd_b)
//   lu_a, lu_b, lu_f      registered operands/opcode to logic unit
//   lu_out, lu_z/n/p      combinational result and flags from logic unit
//   rsp_valid/ready       response handshake (rsp_data, rsp_flags,
//                         rsp_illegal, rsp_mismatch)
//   op_count              completed response handshakes (wrapping)
//   chk_error             sticky result-checker error
//
// Optional: define LOGIC_ISSUER_CHECK_EN to recompute the expected
// result/flags at capture time and flag disagreements from the unit.
// Without it, rsp_mismatch and chk_error are tied to 0.

module logic_op_issuer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_f,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] lu_a,
   output logic [WIDTH-1:0] lu_b,
   output logic [2:0]       lu_f,
   input  logic [WIDTH-1:0] lu_out,
   input  logic             lu_z,
   input  logic             lu_n,
   input  logic             lu_p,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [2:0]       rsp_flags,
   output logic             rsp_illegal,
   output logic [CNT_W-1:0] op_count,
   output logic             rsp_mismatch,
   output logic             chk_error
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic legal;
   logic cmd_take;
   logic rsp_take;
   logic capture;

   // opcodes 1xx are illegal
   assign legal = ~cmd_f[2];

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      cmd_take  = 1'b0;
      rsp_take  = 1'b0;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               cmd_take  = 1'b1;
               state_nxt = legal ? EXEC : RESP;
            end
         end
         EXEC: begin
            capture   = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               rsp_take  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         lu_a        <= '0;
         lu_b        <= '0;
         lu_f        <= 3'b000;
         rsp_data    <= '0;
         rsp_flags   <= 3'b000;
         rsp_illegal <= 1'b0;
         op_count    <= '0;
      end else begin
         state <= state_nxt;
         if (cmd_take && legal) begin
            lu_a <= cmd_a;
            lu_b <= cmd_b;
            lu_f <= cmd_f;
         end
         // illegal ops skip EXEC with a zeroed response
         if (cmd_take && !legal) begin
            rsp_data    <= '0;
            rsp_flags   <= 3'b000;
            rsp_illegal <= 1'b1;
         end
         if (capture) begin
            rsp_data    <= lu_out;
            rsp_flags   <= {lu_z, lu_n, lu_p};
            rsp_illegal <= 1'b0;
         end
         if (rsp_take) begin
            op_count <= op_count + CNT_W'(1);
         end
      end
   end

`ifdef LOGIC_ISSUER_CHECK_EN
   logic [WIDTH-1:0] exp_res;
   logic [2:0]       exp_flags;
   logic             bad_now;

   // lu_f only ever holds legal opcodes
   always_comb begin
      exp_res = '0;
      unique case (lu_f[1:0])
         2'b00:   exp_res = lu_a & lu_b;
         2'b01:   exp_res = lu_a | lu_b;
         2'b10:   exp_res = lu_a ^ lu_b;
         default: exp_res = ~lu_a;
      endcase
      exp_flags = {~|exp_res, exp_res[WIDTH-1], ~^exp_res};
      bad_now   = (lu_out != exp_res) ||
                  ({lu_z, lu_n, lu_p} != exp_flags);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_mismatch <= 1'b0;
         chk_error    <= 1'b0;
      end else begin
         if (cmd_take && !legal) begin
            rsp_mismatch <= 1'b0;
         end
         if (capture) begin
            rsp_mismatch <= bad_now;
            if (bad_now) begin
               chk_error <= 1'b1;
            end
         end
      end
   end
`else
   assign rsp_mismatch = 1'b0;
   assign chk_error    = 1'b0;
`endif

endmodule

// File: tb/tb_logic_op_issuer.sv
// Self-checking bench for logic_op_issuer with a behavioural logic unit
// and a transaction-level model of responses, latency and counting.

module tb_logic_op_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_f;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [15:0] lu_a;
   logic [15:0] lu_b;
   logic [2:0]  lu_f;
   logic [15:0] lu_out;
   logic        lu_z;
   logic        lu_n;
   logic        lu_p;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_flags;
   logic        rsp_illegal;
   logic [15:0] op_count;
   logic        rsp_mismatch;
   logic        chk_error;

   int total = 0;
   int bad   = 0;

   // model state
   logic [15:0] m_a;
   logic [15:0] m_b;
   logic [2:0]  m_f;
   int          m_cnt;
   logic        m_err;
   bit          force_bad = 1'b0;

   logic_op_issuer #(.WIDTH(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_f(cmd_f), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .lu_a(lu_a), .lu_b(lu_b), .lu_f(lu_f),
      .lu_out(lu_out), .lu_z(lu_z), .lu_n(lu_n), .lu_p(lu_p),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags),
      .rsp_illegal(rsp_illegal), .op_count(op_count),
      .rsp_mismatch(rsp_mismatch), .chk_error(chk_error)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_res(
      input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
      case (f)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~a;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [2:0] ref_flags(input logic [15:0] r);
      logic z, n, p;
      z = (r == 16'h0000);
      n = (r >= 16'h8000);
      p = (($countones(r) % 2) == 0);
      return {z, n, p};
   endfunction

   // stand-in logic unit; force_bad corrupts only the result bus
   always_comb begin
      logic [15:0] r;
      r = ref_res(lu_f, lu_a, lu_b);
      lu_out = force_bad ? 16'h0001 : r;
      {lu_z, lu_n, lu_p} = ref_flags(r);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_a = '0; m_b = '0; m_f = '0;
      m_cnt = 0; m_err = 1'b0;
   endtask

   // drive one command, check latency, response, hold and count
   task automatic run_op(input logic [2:0] f, input logic [15:0] a,
                         input logic [15:0] b, input int hold);
      logic [15:0] er;
      logic [2:0]  ef;
      logic        il;
      logic        emm;
      int          n;
      il  = f[2];
      er  = il ? 16'h0 : (force_bad ? 16'h0001 : ref_res(f, a, b));
      ef  = il ? 3'b000 : ref_flags(ref_res(f, a, b));
`ifdef LOGIC_ISSUER_CHECK_EN
      emm = force_bad && !il;
`else
      emm = 1'b0;
`endif
      cmd_valid = 1'b1; cmd_f = f; cmd_a = a; cmd_b = b;
      n = 0;
      while (!cmd_ready && n < 20) begin step(); n++; end
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL accept_timeout got=%b want=1", cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
      if (!il) begin m_a = a; m_b = b; m_f = f; end
      total++;
      if ({lu_a, lu_b, lu_f} !== {m_a, m_b, m_f}) begin
         bad++;
         $display("FAIL lu_regs got=%h/%h/%b want=%h/%h/%b",
                  lu_a, lu_b, lu_f, m_a, m_b, m_f);
      end
      n = 1;
      while (rsp_valid !== 1'b1 && n < 10) begin step(); n++; end
      total++;
      if (n !== (il ? 1 : 2)) begin
         bad++;
         $display("FAIL latency got=%0d want=%0d", n, il ? 1 : 2);
      end
      m_err = m_err | emm;
      for (int i = 0; i <= hold; i++) begin
         total++;
         if ({rsp_valid, rsp_data, rsp_flags, rsp_illegal,
              rsp_mismatch, cmd_ready} !==
             {1'b1, er, ef, il, emm, 1'b0}) begin
            bad++;
            $display("FAIL rsp f=%b got=%b %h %b %b %b rdy=%b want=1 %h %b %b %b rdy=0",
                     f, rsp_valid, rsp_data, rsp_flags, rsp_illegal,
                     rsp_mismatch, cmd_ready, er, ef, il, emm);
         end
         if (i < hold) step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      m_cnt++;
      total++;
      if ({rsp_valid, op_count, chk_error} !==
          {1'b0, 16'(m_cnt), m_err}) begin
         bad++;
         $display("FAIL post_hs got=%b %0d %b want=0 %0d %b",
                  rsp_valid, op_count, chk_error, m_cnt, m_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
      cmd_f = '0; cmd_a = '0; cmd_b = '0;
      step(); step();
      model_reset();
      total++;
      if ({cmd_ready, rsp_valid, lu_a, lu_b, lu_f, rsp_data,
           rsp_flags, rsp_illegal, op_count, rsp_mismatch,
           chk_error} !== {1'b1, 1'b0, 16'h0, 16'h0, 3'b0, 16'h0,
           3'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_state rdy=%b v=%b a=%h f=%b d=%h cnt=%0d err=%b",
                  cmd_ready, rsp_valid, lu_a, lu_f, rsp_data,
                  op_count, chk_error);
      end
      rst_n = 1'b1; rsp_ready = 1'b0;
      step();
   endtask

   task automatic test_directed();
      run_op(3'b000, 16'h00FF, 16'h0F0F, 0);
      run_op(3'b011, 16'h0000, 16'h5555, 0);
      run_op(3'b010, 16'h1234, 16'h1234, 1);
   endtask

   task automatic test_illegal();
      run_op(3'b101, 16'hAAAA, 16'h5555, 0);
      run_op(3'b111, 16'hFFFF, 16'h0001, 2);
   endtask

   task automatic test_back_to_back();
      logic [15:0] r1, r2;
      r1 = ref_res(3'b001, 16'h1200, 16'h0034);
      r2 = ref_res(3'b000, 16'hF0F0, 16'hFF00);
      cmd_valid = 1'b1; cmd_f = 3'b001;
      cmd_a = 16'h1200; cmd_b = 16'h0034;
      step();
      m_a = 16'h1200; m_b = 16'h0034; m_f = 3'b001;
      // next command held from EXEC onward
      cmd_f = 3'b000; cmd_a = 16'hF0F0; cmd_b = 16'hFF00;
      step();
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({rsp_valid, rsp_data, cmd_ready, lu_a} !==
             {1'b1, r1, 1'b0, m_a}) begin
            bad++;
            $display("FAIL bp_hold got=%b %h %b %h want=1 %h 0 %h",
                     rsp_valid, rsp_data, cmd_ready, lu_a, r1, m_a);
         end
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      m_cnt++;
      total++;
      if ({cmd_ready, rsp_valid, op_count} !==
          {1'b1, 1'b0, 16'(m_cnt)}) begin
         bad++;
         $display("FAIL bp_release got=%b %b %0d want=1 0 %0d",
                  cmd_ready, rsp_valid, op_count, m_cnt);
      end
      step();
      cmd_valid = 1'b0;
      m_a = 16'hF0F0; m_b = 16'hFF00; m_f = 3'b000;
      total++;
      if ({cmd_ready, lu_a, lu_b, lu_f} !==
          {1'b0, m_a, m_b, m_f}) begin
         bad++;
         $display("FAIL b2b_accept got=%b %h %h %b want=0 %h %h %b",
                  cmd_ready, lu_a, lu_b, lu_f, m_a, m_b, m_f);
      end
      step();
      total++;
      if ({rsp_valid, rsp_data, rsp_flags} !==
          {1'b1, r2, ref_flags(r2)}) begin
         bad++;
         $display("FAIL b2b_rsp got=%b %h %b want=1 %h %b",
                  rsp_valid, rsp_data, rsp_flags, r2, ref_flags(r2));
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      m_cnt++;
   endtask

   task automatic test_reset_mid_exec();
      cmd_valid = 1'b1; cmd_f = 3'b001;
      cmd_a = 16'hBEEF; cmd_b = 16'h0101;
      step();
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      model_reset();
      total++;
      if ({cmd_ready, rsp_valid, op_count, lu_a, lu_b, lu_f} !==
          {1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 3'b0}) begin
         bad++;
         $display("FAIL exec_reset got=%b %b %0d %h %h %b",
                  cmd_ready, rsp_valid, op_count, lu_a, lu_b, lu_f);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL exec_reset_norsp got=%b want=0", rsp_valid);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), 16'($urandom),
                16'($urandom), int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_checker();
      force_bad = 1'b1;
      run_op(3'b000, 16'h0000, 16'h0000, 0);
      force_bad = 1'b0;
      run_op(3'b001, 16'h8001, 16'h0100, 0);
      run_op(3'b110, 16'h0000, 16'h0000, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_illegal();
      test_back_to_back();
      test_reset_mid_exec();
      test_random();
      test_checker();
      test_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
